// File: rtl/adder_seq_pkg.sv
// Shared definitions for the adder sequencer.
// Provides the FSM encoding, the operand word geometry, the operand-assembly
// record and the byte-load helper used for both operands.
package adder_seq_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CNT_BITS       = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // One operand under assembly: the word, the next byte slot and the full flag.
  typedef struct packed {
    logic [WORD_W-1:0]   word;
    logic [CNT_BITS-1:0] cnt;
    logic                full;
  } operand_t;

  // Applies one button pulse to an operand. A pulse on a full operand starts
  // it over at byte 0; the stale upper bytes are overwritten before it fills.
  function automatic operand_t load_byte(operand_t op, logic [7:0] val);
    operand_t res;
    res = op;
    if (op.full) begin
      res.word[7:0] = val;
      res.cnt       = CNT_BITS'(1);
      res.full      = 1'b0;
    end else begin
      res.word[8*op.cnt +: 8] = val;
      res.full                = (op.cnt == CNT_MAX);
      res.cnt                 = op.cnt + 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Push-button front end: two-flop synchroniser, optional debounce, and a
// rising-edge detector producing one clock-wide pulse per press.
// Optional feature macro: ADDER_SEQ_DEBOUNCE_EN (debounce counter enabled).
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   btn   - raw button level, asynchronous to clk
//   pulse - single-cycle pulse on each accepted press
module btn_pulse #(
  parameter int unsigned      CNT_W           = 16,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync1_q, sync2_q;
  logic level;
  logic level_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

`ifdef ADDER_SEQ_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;

  // The level only follows the synced input after it has disagreed for
  // DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == DEBOUNCE_CYCLES - 1'b1) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign level = deb_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^DEBOUNCE_CYCLES;
  assign level      = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev_q <= 1'b0;
    end else begin
      level_prev_q <= level;
    end
  end

  assign pulse = level & ~level_prev_q;

endmodule

// File: rtl/carry_select_adder.sv
// 32-bit combinational carry-select adder: the lower half ripples from cin,
// the upper half is computed for both carry values and selected by the lower
// half's carry-out.
// Ports:
//   a, b - 32-bit operands
//   cin  - carry-in
//   sum  - 32-bit sum
//   cout - carry-out
module carry_select_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [16:0] lo, hi0, hi1;

  assign lo  = {1'b0, a[15:0]}  + {1'b0, b[15:0]}  + {16'd0, cin};
  assign hi0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
  assign hi1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;

  assign sum[15:0]     = lo[15:0];
  assign {cout, sum[31:16]} = lo[16] ? hi1 : hi0;

endmodule

// File: rtl/adder_sequencer.sv
// Board front end for the 32-bit carry-select adder. Operands A and B are
// assembled LSB-first from the switch byte under push-button strobes, one
// registered add is run, and the sum is shown a byte at a time on the LEDs.
// Optional feature macro: ADDER_SEQ_DEBOUNCE_EN (button debounce in btn_pulse).
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   inp            - switch byte to load
//   cin            - adder carry-in, sampled in the add cycle
//   setA, setB     - raw push-buttons loading the next byte of A / B
//   select         - sum byte shown on out (0 = LSB)
//   out, cout      - selected sum byte and carry-out, zero while not done
//   setaled/setbled       - A / B fully loaded
//   select0led/select1led - mirror select
//   done           - result valid
module adder_sequencer
  import adder_seq_pkg::*;
#(
  parameter int unsigned      CNT_W           = 16,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] inp,
  input  logic       cin,
  input  logic       setA,
  input  logic       setB,
  input  logic [1:0] select,
  output logic [7:0] out,
  output logic       cout,
  output logic       setaled,
  output logic       setbled,
  output logic       select0led,
  output logic       select1led,
  output logic       done
);

  logic a_pls, b_pls;

  btn_pulse #(
    .CNT_W          (CNT_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_a (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (setA),
    .pulse(a_pls)
  );

  btn_pulse #(
    .CNT_W          (CNT_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_b (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (setB),
    .pulse(b_pls)
  );

  state_e            state_q, state_d;
  operand_t          op_a_q, op_a_d, op_b_q, op_b_d;
  logic [WORD_W-1:0] sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              done_q, done_d;
  logic [WORD_W-1:0] add_sum;
  logic              add_cout;

  carry_select_adder u_adder (
    .a   (op_a_q.word),
    .b   (op_b_q.word),
    .cin (cin),
    .sum (add_sum),
    .cout(add_cout)
  );

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = done_q;

    // Byte loading is independent of the FSM so both buttons can land at once.
    if (a_pls) begin
      op_a_d = load_byte(op_a_q, inp);
    end
    if (b_pls) begin
      op_b_d = load_byte(op_b_q, inp);
    end

    unique case (state_q)
      LOAD: begin
        if (op_a_q.full && op_b_q.full) begin
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d   = add_sum;
        cout_d  = add_cout;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (a_pls || b_pls) begin
          done_d  = 1'b0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign out        = done_q ? sum_q[8*select +: 8] : 8'h00;
  assign cout       = done_q & cout_q;
  assign done       = done_q;
  assign setaled    = op_a_q.full;
  assign setbled    = op_b_q.full;
  assign select0led = select[0];
  assign select1led = select[1];

endmodule

// File: tb/tb_adder_sequencer.sv
module tb_adder_sequencer;

`ifdef ADDER_SEQ_DEBOUNCE_EN
  localparam int HOLD = 10;
  localparam int GAP  = 14;
  localparam int LAT  = 9;   // drive edge to done: 2 sync + 4 debounce + write + LOAD + CALC
`else
  localparam int HOLD = 3;
  localparam int GAP  = 7;
  localparam int LAT  = 5;   // drive edge to done: 2 sync + write + LOAD + CALC
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] inp;
  logic       cin;
  logic       setA, setB;
  logic [1:0] select;
  logic [7:0] out;
  logic       cout, setaled, setbled, select0led, select1led, done;

  always #5 clk = ~clk;

  adder_sequencer #(
    .CNT_W          (16),
    .DEBOUNCE_CYCLES(16'd4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inp       (inp),
    .cin       (cin),
    .setA      (setA),
    .setB      (setB),
    .select    (select),
    .out       (out),
    .cout      (cout),
    .setaled   (setaled),
    .setbled   (setbled),
    .select0led(select0led),
    .select1led(select1led),
    .done      (done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: operands as byte arrays, result as plain 33-bit addition.
  logic [7:0]  ma[4];
  logic [7:0]  mb[4];
  int          ma_cnt, mb_cnt;
  bit          ma_full, mb_full, mdone;
  logic [32:0] mres;

  task automatic m_clear();
    for (int i = 0; i < 4; i++) begin
      ma[i] = 8'h00;
      mb[i] = 8'h00;
    end
    ma_cnt = 0; mb_cnt = 0;
    ma_full = 0; mb_full = 0; mdone = 0;
    mres = '0;
  endtask

  task automatic m_press(input bit pa, input bit pb, input logic [7:0] v);
    if (pa) begin
      if (ma_full) begin
        ma[0] = v; ma_cnt = 1; ma_full = 0;
      end else begin
        ma[ma_cnt] = v;
        if (ma_cnt == 3) begin ma_full = 1; ma_cnt = 0; end
        else ma_cnt++;
      end
    end
    if (pb) begin
      if (mb_full) begin
        mb[0] = v; mb_cnt = 1; mb_full = 0;
      end else begin
        mb[mb_cnt] = v;
        if (mb_cnt == 3) begin mb_full = 1; mb_cnt = 0; end
        else mb_cnt++;
      end
    end
    mdone = 0;
    if (ma_full && mb_full) begin
      mdone = 1;
      mres  = {1'b0, ma[3], ma[2], ma[1], ma[0]} + {1'b0, mb[3], mb[2], mb[1], mb[0]}
            + {32'd0, cin};
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] exp_out;
    check({tag, "_setaled"}, setaled, ma_full);
    check({tag, "_setbled"}, setbled, mb_full);
    check({tag, "_done"}, done, mdone);
    check({tag, "_cout"}, cout, mdone ? mres[32] : 1'b0);
    for (int s = 0; s < 4; s++) begin
      select = 2'(s);
      #1;
      exp_out = mdone ? mres[8*s +: 8] : 8'h00;
      check($sformatf("%s_out%0d", tag, s), out, exp_out);
      check($sformatf("%s_led%0d", tag, s), {select1led, select0led}, s);
    end
  endtask

  task automatic press(input bit pa, input bit pb, input logic [7:0] v, input string tag);
    bit completing;
    int first;
    m_press(pa, pb, v);
    completing = mdone;
    first = 0;
    @(posedge clk); #1;
    inp = v; setA = pa; setB = pb;
    for (int e = 1; e <= HOLD + GAP; e++) begin
      @(posedge clk); #1;
      if (e == HOLD) begin setA = 1'b0; setB = 1'b0; end
      if (done && first == 0) first = e;
    end
    if (completing) check({tag, "_latency"}, first, LAT);
    check_state(tag);
  endtask

  task automatic load_word(input bit is_a, input logic [31:0] w, input string tag);
    for (int i = 0; i < 4; i++) press(is_a, !is_a, w[8*i +: 8], tag);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    m_clear();
    check({tag, "_rst_setaled"}, setaled, 1'b0);
    check({tag, "_rst_setbled"}, setbled, 1'b0);
    check({tag, "_rst_done"}, done, 1'b0);
    check({tag, "_rst_out"}, out, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit pa, pb;
    int r, guard;
    rst_n = 1'b0; inp = 8'h00; cin = 1'b0; setA = 1'b0; setB = 1'b0; select = 2'd0;
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_state("reset");

    // Directed vectors from the test plan.
    press(1, 0, 8'h03, "first_a");
    press(1, 0, 8'h02, "dir_a"); press(1, 0, 8'h07, "dir_a"); press(1, 0, 8'hFF, "dir_a");
    load_word(0, 32'h10C02301, "dir_b");
    check("dir_sum_lsb", out, 8'h0F);   // select is left at 3 by check_state
    cin = 1'b1;
    load_word(1, 32'hFF070203, "dir_cin1");
    cin = 1'b0;
    press(1, 0, 8'h80, "restart");
    load_word(1, 32'h00000000, "restart_fill");   // bytes 1-3 only matter after restart
    do_reset("pre_simul");
    press(1, 0, 8'h80, "restart2");
    press(1, 0, 8'h00, "restart2"); press(1, 0, 8'h00, "restart2"); press(1, 0, 8'h00, "restart2");
    load_word(0, 32'h10C02301, "restart2_b");

    // Simultaneous presses in LOAD advance both operands.
    do_reset("simul");
    press(1, 1, 8'h5A, "simul_both");
    for (int i = 0; i < 3; i++) press(1, 0, 8'(8'h11 * (i + 1)), "simul_a");
    for (int i = 0; i < 3; i++) press(0, 1, 8'(8'h21 * (i + 1)), "simul_b");

    // Reset in the middle of loading A.
    do_reset("midload");
    press(1, 0, 8'hAA, "midload_a"); press(1, 0, 8'hBB, "midload_a");
    do_reset("midload2");
    load_word(1, 32'hDEADBEEF, "reload_a");
    load_word(0, 32'h21524111, "reload_b");

`ifdef ADDER_SEQ_DEBOUNCE_EN
    // A short glitch must not load a byte.
    do_reset("glitch");
    @(posedge clk); #1;
    inp = 8'h55; setA = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    setA = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;
    check_state("glitch");
    load_word(1, 32'h01020304, "glitch_a");
    load_word(0, 32'hF0E0D0C0, "glitch_b");
`endif

    // Randomised rounds with interleaved button order.
    for (int round = 0; round < 6; round++) begin
      cin = 1'($urandom_range(0, 1));
      guard = 0;
      do begin
        r = $urandom_range(0, 7);
        pa = 0; pb = 0;
        if (r == 0) begin pa = 1; pb = 1; end
        else if (ma_full && !mb_full) pb = 1;
        else if (mb_full && !ma_full) pa = 1;
        else if (r < 4) pa = 1;
        else pb = 1;
        press(pa, pb, 8'($urandom), "rand");
        guard++;
      end while (!mdone && guard < 40);
      check("rand_round_done", done, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_sequencer.md
Name: adder_sequencer

Overview:
- Board-level front end for the 32-bit carry-select adder.
- Assembles operands A and B byte-by-byte from 8 switches under push-button strobes, then runs one registered add.
- Presents the 32-bit sum one byte at a time on 8 LEDs, chosen by a 2-bit select.
- Sits between the board I/O pins and the existing combinational carry-select adder, which it instantiates and sequences.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: clocks a synchronised button must hold steady before an edge counts. Used only with DEBOUNCE_EN.
- CNT_W, 16: width of the debounce counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- inp  in  8  switch byte to load
- cin  in  1  adder carry-in
- setA  in  1  push-button, load next byte of A (asynchronous to clk)
- setB  in  1  push-button, load next byte of B (asynchronous to clk)
- select  in  2  result byte shown on out (0 = LSB)
- out  out  8  selected sum byte
- cout  out  1  adder carry-out
- setaled  out  1  A fully loaded
- setbled  out  1  B fully loaded
- select0led  out  1  mirrors select[0]
- select1led  out  1  mirrors select[1]
- done  out  1  result valid

Behaviour:
- Reset: asynchronous, active-low (rst_n), single clock clk. All registers clear: A, B, sum, a_cnt, b_cnt, a_full, b_full, cout, done, out = 0; FSM in LOAD.
- Button path: setA and setB each pass through a 2-flop synchroniser, then rising-edge detect. Result is a 1-cycle pulse (a_pls, b_pls) per press. Holding a button produces exactly one pulse.
- Byte order: a_pls writes inp into A[8*a_cnt +: 8], then a_cnt increments. The first byte loaded is the LSB. b_pls does the same for B with b_cnt.
- Full flags: the write at cnt = 3 sets a_full (or b_full) and wraps cnt to 0.
- Pulse while that operand is already full: restarts that operand. The byte goes to byte 0, cnt becomes 1, the full flag clears, done clears.
- Simultaneous a_pls and b_pls: both accepted in the same cycle, independently.
- FSM states: LOAD -> CALC -> DONE.
  - LOAD: stays here until a_full & b_full are both 1 (as registered at the start of the cycle); then goes to CALC.
  - CALC: exactly 1 cycle. Adder inputs are A, B and cin sampled this cycle. At the clock edge ending CALC, {cout, sum} is registered and done is set to 1. Go to DONE.
  - DONE: holds. Any a_pls or b_pls returns to LOAD in the same cycle; that byte is written per the restart rule and done clears.
- Latency: done rises 2 clocks after the cycle in which the final byte is written.
- Adder arithmetic: {cout, sum} = A + B + cin, giving a 33-bit result. No signedness.
- out:
  - When done = 1: sum[8*select +: 8], combinational on select.
  - When done = 0: 8'h00.
- cout: the registered value while done = 1; 0 otherwise.
- LEDs: setaled = a_full, setbled = b_full. select0led and select1led are combinational from select.
- Reset mid-load or mid-CALC: everything returns to reset values and no partial result is kept.

Optional Feature:
- Macro: ADDER_SEQ_DEBOUNCE_EN.
- Defined: each synchronised button feeds a debounce counter. The debounced level changes only after the synced input differs from it for DEBOUNCE_CYCLES consecutive clocks, and the edge detect operates on the debounced level. Pulse latency is 2 + DEBOUNCE_CYCLES clocks from the pin.
- Undefined: no counter; edge detect runs directly on the synchroniser output, 2-3 clocks from the pin. DEBOUNCE_CYCLES is unused.

Decomposition:
- Package adder_seq_pkg holds:
  - state encoding: LOAD = 2'd0, CALC = 2'd1, DONE = 2'd2
  - BYTES_PER_WORD = 4
  - WORD_W = 32
- One sub-module, btn_pulse: synchroniser, optional debounce, rising-edge pulse. Instantiated twice, for setA and setB.
- The existing 32-bit carry-select adder is instantiated unchanged.

Test Plan:
- After reset: all outputs 0. Press setA with no other input -> A[7:0] loads, setaled stays 0, done stays 0.
- Load A bytes 03, 02, 07, FF and B bytes 01, 23, C0, 10, with cin = 0:
  - A = FF070203, B = 10C02301, setaled = setbled = 1
  - done = 1 two clocks after the final setB edge, cout = 1
  - select 0/1/2/3 -> out = 04 / 25 / C7 / 0F, and select0led/select1led follow select
- Repeat with cin = 1 -> byte 0 = 05, all other bytes unchanged.
- In DONE, press setA with inp = 0x80:
  - done = 0, out = 00, setaled = 0, A byte 0 = 80
  - Load A bytes 1-3 as 00 -> A = 00000080; sum = 10C02381, cout = 0
- Assert setA and setB in the same clock during LOAD -> both counters advance by 1.
- Drop rst_n mid-load, after two A bytes -> counters and flags clear at once; a full reload then gives the correct sum.
- Define ADDER_SEQ_DEBOUNCE_EN with DEBOUNCE_CYCLES = 4:
  - a 3-cycle glitch on setA -> no load
  - a 10-cycle press -> exactly one byte loaded
